ovc_tracker: RTL and testbench

OVC_TRACKER -- requirements
Module: ovc_tracker

---
 rtl/ovc_tracker.sv | 137 +++++++++++++
 tb/tb_ovc_tracker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ovc_tracker.sv
// ovc_tracker: tracks the allocation state and downstream credit count of
// every output virtual channel of a router (PORTS x CHANNELS VCs).
// Global VC id j = port*CHANNELS + ch.
// Optional feature: define OVC_ATOMIC_REALLOC_EN to keep a VC in DRAIN after
// its tail departs, so it can be reallocated only once all credits return.
// Without it, a VC is released as soon as its tail flit departs.
module ovc_tracker #(
  parameter  int VID_BITS = 6,
  parameter  int PORTS    = 5,
  parameter  int CHANNELS = 12,
  parameter  int CREDITS  = 4,
  localparam int NUM_VC   = PORTS * CHANNELS,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_VC-1:0]            vc_gnt,
  input  logic [NUM_VC*VID_BITS-1:0]   g_ovid,
  input  logic [PORTS-1:0]             sa_fire,
  input  logic [PORTS*CH_W-1:0]        sa_vc,
  input  logic [PORTS-1:0]             sa_tail,
  input  logic [PORTS-1:0]             cr_valid,
  input  logic [PORTS*CH_W-1:0]        cr_vc,
  output logic [NUM_VC-1:0]            ovid_avail,
  output logic [NUM_VC-1:0]            credit_avail,
  output logic [2:0]                   err
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} vc_state_e;

  logic [NUM_VC-1:0] ovf_vec;      // credit arrived at a full counter
  logic [NUM_VC-1:0] no_cred_vec;  // flit sent on a VC without credit
  logic [NUM_VC-1:0] gnt_err_vec;  // duplicate grant or grant to a busy VC
  logic              range_err;    // grant carried an id beyond the last VC
  logic [2:0]        err_q, err_d;

  // Flag any grant whose VC id does not exist
  always_comb begin
    range_err = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (vc_gnt[i] && (int'(g_ovid[i*VID_BITS +: VID_BITS]) >= NUM_VC)) begin
        range_err = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    localparam int                  P   = gi / CHANNELS;
    localparam logic [CH_W-1:0]     CH  = CH_W'(gi % CHANNELS);
    localparam logic [VID_BITS-1:0] VID = VID_BITS'(gi);

    vc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_VC-1:0] hits;
    logic              fire, tail, credit;
    logic              gnt_hit, gnt_multi;
    logic              ovf, no_cred;

    // Collect every requester granted this VC in the current cycle
    always_comb begin
      hits = '0;
      for (int i = 0; i < NUM_VC; i++) begin
        hits[i] = vc_gnt[i] && (g_ovid[i*VID_BITS +: VID_BITS] == VID);
      end
    end

    assign fire      = sa_fire[P] && (sa_vc[P*CH_W +: CH_W] == CH);
    assign tail      = fire && sa_tail[P];
    assign credit    = cr_valid[P] && (cr_vc[P*CH_W +: CH_W] == CH);
    assign gnt_hit   = |hits;
    // More than one bit set means two requesters collided on this id; the
    // lowest-index requester still takes an IDLE VC, the rest are flagged.
    assign gnt_multi = |(hits & (hits - NUM_VC'(1)));

    // Credit counter update (saturating both ways) and VC state transition
    always_comb begin
      cnt_d   = cnt_q;
      ovf     = 1'b0;
      no_cred = 1'b0;
      if (fire && !credit) begin
        if (cnt_q == '0) no_cred = 1'b1;
        else             cnt_d   = cnt_q - CNT_ONE;
      end else if (credit && !fire) begin
        if (cnt_q == CNT_FULL) ovf   = 1'b1;
        else                   cnt_d = cnt_q + CNT_ONE;
      end

      state_d = state_q;
      case (state_q)
        ST_IDLE:   if (gnt_hit) state_d = ST_ACTIVE;
`ifdef OVC_ATOMIC_REALLOC_EN
        ST_ACTIVE: if (tail) state_d = ST_DRAIN;
`else
        ST_ACTIVE: if (tail) state_d = ST_IDLE;
`endif
        // Release only once the downstream buffer is completely empty
        ST_DRAIN:  if (cnt_d == CNT_FULL) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // Per-VC state and credit registers
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= CNT_FULL;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign ovid_avail[gi]   = (state_q == ST_IDLE);
    assign credit_avail[gi] = (cnt_q != '0);
    assign ovf_vec[gi]      = ovf;
    assign no_cred_vec[gi]  = no_cred;
    assign gnt_err_vec[gi]  = gnt_multi || (gnt_hit && (state_q != ST_IDLE));
  end

  // Accumulate error conditions; bits stay set until reset
  always_comb begin
    err_d = err_q | {|ovf_vec, |no_cred_vec, range_err | (|gnt_err_vec)};
  end

  // Sticky error register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= '0;
    else      err_q <= err_d;
  end

  assign err = err_q;

endmodule

// File: tb/tb_ovc_tracker.sv
// tb_ovc_tracker: directed, table-driven bench for ovc_tracker (default
// parameters). Expectations for the drain window follow the
// OVC_ATOMIC_REALLOC_EN build setting.
module tb_ovc_tracker;

  localparam int VID_BITS = 6;
  localparam int PORTS    = 5;
  localparam int CHANNELS = 12;
  localparam int CREDITS  = 4;
  localparam int NUM_VC   = PORTS * CHANNELS;
  localparam int CH_W     = $clog2(CHANNELS);

`ifdef OVC_ATOMIC_REALLOC_EN
  localparam bit ATOMIC = 1'b1;
`else
  localparam bit ATOMIC = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [NUM_VC-1:0]          vc_gnt;
  logic [NUM_VC*VID_BITS-1:0] g_ovid;
  logic [PORTS-1:0]           sa_fire;
  logic [PORTS*CH_W-1:0]      sa_vc;
  logic [PORTS-1:0]           sa_tail;
  logic [PORTS-1:0]           cr_valid;
  logic [PORTS*CH_W-1:0]      cr_vc;
  logic [NUM_VC-1:0]          ovid_avail;
  logic [NUM_VC-1:0]          credit_avail;
  logic [2:0]                 err;

  ovc_tracker #(
    .VID_BITS(VID_BITS), .PORTS(PORTS), .CHANNELS(CHANNELS), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .rst(rst), .vc_gnt(vc_gnt), .g_ovid(g_ovid),
    .sa_fire(sa_fire), .sa_vc(sa_vc), .sa_tail(sa_tail),
    .cr_valid(cr_valid), .cr_vc(cr_vc),
    .ovid_avail(ovid_avail), .credit_avail(credit_avail), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       gnt;   int gnt_req; int gnt_id;
    bit       fire;  int f_port;  int f_vc;  bit tail;
    bit       cr;    int c_port;  int c_vc;
    bit       e_ovid14;
    bit       e_cred14;
    bit [2:0] e_err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    vc_gnt = '0; g_ovid = '0; sa_fire = '0; sa_vc = '0;
    sa_tail = '0; cr_valid = '0; cr_vc = '0;
  endtask

  task automatic drive_gnt(input int req, input int id);
    vc_gnt[req] = 1'b1;
    g_ovid[req*VID_BITS +: VID_BITS] = VID_BITS'(id);
  endtask

  task automatic drive_fire(input int p, input int vc, input bit tl);
    sa_fire[p] = 1'b1;
    sa_vc[p*CH_W +: CH_W] = CH_W'(vc);
    sa_tail[p] = tl;
  endtask

  task automatic drive_cr(input int p, input int vc);
    cr_valid[p] = 1'b1;
    cr_vc[p*CH_W +: CH_W] = CH_W'(vc);
  endtask

  // Holds reset for two cycles with idle inputs; returns on a negedge with rst high
  task automatic do_reset();
    clear_in();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_all(input string name, input logic [NUM_VC-1:0] e_ovid,
                         input logic [NUM_VC-1:0] e_cred, input logic [2:0] e_err);
    chk({name, " ovid_avail"},   64'(ovid_avail),   64'(e_ovid));
    chk({name, " credit_avail"}, 64'(credit_avail), 64'(e_cred));
    chk({name, " err"},          64'(err),          64'(e_err));
  endtask

  logic [NUM_VC-1:0] ones;
  logic [NUM_VC-1:0] exp_o;
  logic [NUM_VC-1:0] exp_c;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit na;
    na   = !ATOMIC;
    ones = '1;
    clear_in();

    // VC 14 = port 1, local vc 2. Each row is one clock; expectations are
    // the registered outputs after that clock edge.
    //             gnt req id   fire p v tail  cr p v   ovid14 cred14 err
    vecs[0]  = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  1,  1, 3'b000}; // idle
    vecs[1]  = '{1, 3, 14, 0, 0, 0, 0,  0, 0, 0,  0,  1, 3'b000}; // grant -> ACTIVE
    vecs[2]  = '{0, 0, 0,  1, 1, 2, 0,  0, 0, 0,  0,  1, 3'b000}; // cnt 3
    vecs[3]  = '{0, 0, 0,  1, 1, 2, 0,  0, 0, 0,  0,  1, 3'b000}; // cnt 2
    vecs[4]  = '{0, 0, 0,  1, 1, 2, 0,  0, 0, 0,  0,  1, 3'b000}; // cnt 1
    vecs[5]  = '{0, 0, 0,  1, 1, 2, 0,  0, 0, 0,  0,  0, 3'b000}; // cnt 0
    vecs[6]  = '{0, 0, 0,  1, 1, 2, 0,  0, 0, 0,  0,  0, 3'b010}; // send without credit
    vecs[7]  = '{0, 0, 0,  0, 0, 0, 0,  1, 1, 2,  0,  1, 3'b010}; // cnt 1
    vecs[8]  = '{0, 0, 0,  0, 0, 0, 0,  1, 1, 2,  0,  1, 3'b010}; // cnt 2
    vecs[9]  = '{0, 0, 0,  1, 1, 2, 0,  1, 1, 2,  0,  1, 3'b010}; // fire+credit: cnt 2
    vecs[10] = '{0, 0, 0,  1, 1, 2, 1,  0, 0, 0,  na, 1, 3'b010}; // tail: cnt 1
    vecs[11] = '{0, 0, 0,  0, 0, 0, 0,  1, 1, 2,  na, 1, 3'b010}; // cnt 2
    vecs[12] = '{0, 0, 0,  0, 0, 0, 0,  1, 1, 2,  na, 1, 3'b010}; // cnt 3
    vecs[13] = '{0, 0, 0,  0, 0, 0, 0,  1, 1, 2,  1,  1, 3'b010}; // cnt 4 -> IDLE
    vecs[14] = '{0, 0, 0,  0, 0, 0, 0,  1, 1, 2,  1,  1, 3'b110}; // credit overflow
    vecs[15] = '{0, 0, 0,  1, 1, 2, 1,  0, 0, 0,  1,  1, 3'b110}; // tail on IDLE VC: cnt 3
    vecs[16] = '{0, 0, 0,  1, 4, 11, 0, 0, 0, 0,  1,  1, 3'b110}; // other port/VC only

    // Reset state, sampled while reset is held
    #12;
    chk_all("reset", ones, ones, 3'b000);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < NV; k++) begin
      clear_in();
      if (vecs[k].gnt)  drive_gnt(vecs[k].gnt_req, vecs[k].gnt_id);
      if (vecs[k].fire) drive_fire(vecs[k].f_port, vecs[k].f_vc, vecs[k].tail);
      if (vecs[k].cr)   drive_cr(vecs[k].c_port, vecs[k].c_vc);
      @(negedge clk);
      exp_o = ones; exp_o[14] = vecs[k].e_ovid14;
      exp_c = ones; exp_c[14] = vecs[k].e_cred14;
      chk_all($sformatf("row%0d", k), exp_o, exp_c, vecs[k].e_err);
    end

    // Grant with an id beyond the last VC is ignored and flagged
    do_reset();
    drive_gnt(1, 62);
    @(negedge clk);
    chk_all("range_gnt", ones, ones, 3'b001);

    // Second grant to an already ACTIVE VC is flagged
    do_reset();
    drive_gnt(2, 7);
    @(negedge clk);
    exp_o = ones; exp_o[7] = 1'b0;
    chk_all("gnt_vc7", exp_o, ones, 3'b000);
    clear_in();
    drive_gnt(4, 7);
    @(negedge clk);
    chk_all("busy_gnt", exp_o, ones, 3'b001);

    // Two requesters with the same id in one cycle
    do_reset();
    drive_gnt(0, 7);
    drive_gnt(5, 7);
    @(negedge clk);
    chk_all("dup_gnt", exp_o, ones, 3'b001);

    // Drive VC 14 into its post-tail state and VC 0 to zero credits
    do_reset();
    drive_gnt(3, 14);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      clear_in();
      drive_fire(0, 0, 1'b0);
      if (c < 3) drive_fire(1, 2, (c == 2));
      @(negedge clk);
    end
    clear_in();
    drive_gnt(8, 63);
    @(negedge clk);
    exp_o = ones; exp_o[14] = na;
    exp_c = ones; exp_c[0] = 1'b0;
    chk_all("pre_rst", exp_o, exp_c, 3'b001);

    // Asynchronous reset mid-cycle with traffic in flight
    #2;
    drive_gnt(3, 14);
    drive_cr(1, 2);
    drive_fire(0, 0, 1'b0);
    rst = 1'b0;
    #1;
    chk_all("async_rst", ones, ones, 3'b000);
    @(posedge clk);
    #1;
    chk_all("rst_held", ones, ones, 3'b000);
    clear_in();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all("post_rst", ones, ones, 3'b000);
    drive_gnt(3, 14);
    @(negedge clk);
    exp_o = ones; exp_o[14] = 1'b0;
    chk_all("regrant", exp_o, ones, 3'b000);
    clear_in();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
